jogador_automatico: RTL and testbench

- Automated player for jogo_desafio_memoria: the other end of the LED/button interface.
- Watches the game's `leds` output while a sequence is displayed, captures it, then replays it on `botoes` with human-like press/release timing.
- Can deliberately inject one wrong press at a chosen index.
- Lets benches and the board run full games (win, loss, consecutive games without reset) with no manual stimulus.

---
 rtl/jogador_automatico_pkg.sv | 23 ++
 rtl/jogador_automatico_memoria.sv | 22 ++
 rtl/jogador_automatico.sv | 188 ++++++++++++++++++
 tb/tb_jogador_automatico.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogador_automatico_pkg.sv
// Shared definitions for the automatic player: state encoding, default
// timing constants and the one-hot LED check.
package jogador_automatico_pkg;

    typedef enum logic [3:0] {
        OCIOSO         = 4'd0,
        PULSO_JOGAR    = 4'd1,
        OBSERVA        = 4'd2,
        REPRODUZ_PRESS = 4'd3,
        REPRODUZ_SOLTA = 4'd4,
        AGUARDA_RODADA = 4'd5,
        FIM            = 4'd6
    } estado_t;

    localparam int unsigned T_PRESS_PADRAO    = 100;
    localparam int unsigned T_GAP_PADRAO      = 100;
    localparam int unsigned T_SILENCIO_PADRAO = 50;

    function automatic logic one_hot(input logic [3:0] v);
        return (v != '0) && ((v & (v - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/jogador_automatico_memoria.sv
// Captured-sequence store: synchronous write, asynchronous read.
module memoria_sequencia #(
    parameter int unsigned PROF = 16,
    parameter int unsigned AW   = 4
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [3:0]    rdata
);

    logic [3:0] mem [PROF];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: captures the LED sequence shown by the memory game and
// replays it on the buttons, optionally pressing one wrong button on purpose.
module jogador_automatico
    import jogador_automatico_pkg::*;
#(
    parameter int unsigned PROF       = 16,
    parameter int unsigned T_PRESS    = T_PRESS_PADRAO,
    parameter int unsigned T_GAP      = T_GAP_PADRAO,
    parameter int unsigned T_SILENCIO = T_SILENCIO_PADRAO,
    parameter int unsigned T_JOGAR    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       erro_en,
    input  logic [3:0] erro_idx,
    input  logic [3:0] leds,
    input  logic       ganhou,
    input  logic       perdeu,
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic       fim_jogo,
    output logic       resultado,
    output logic       falha,
    output logic [3:0] db_estado
);

    localparam int unsigned AW    = (PROF > 1) ? $clog2(PROF) : 1;
    localparam int unsigned NW    = $clog2(PROF) + 1;
    localparam int unsigned T_M1  = (T_PRESS > T_GAP) ? T_PRESS : T_GAP;
    localparam int unsigned T_M2  = (T_M1 > T_SILENCIO) ? T_M1 : T_SILENCIO;
    localparam int unsigned T_MAX = (T_M2 > T_JOGAR) ? T_M2 : T_JOGAR;
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    estado_t       state, state_d;
    logic [NW-1:0] n, n_d;
    logic [AW-1:0] i, i_d;
    logic [TW-1:0] timer, timer_d;
    logic [3:0]    leds_q;
    logic [3:0]    botoes_d;
    logic          falha_d, resultado_d;
    logic          we;
    logic [3:0]    rd_data;

    memoria_sequencia #(
        .PROF (PROF),
        .AW   (AW)
    ) u_mem (
        .clock (clock),
        .we    (we),
        .waddr (n[AW-1:0]),
        .wdata (leds),
        .raddr (i_d),
        .rdata (rd_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= OCIOSO;
            n         <= '0;
            i         <= '0;
            timer     <= '0;
            leds_q    <= '0;
            botoes    <= '0;
            falha     <= 1'b0;
            resultado <= 1'b0;
        end else begin
            state     <= state_d;
            n         <= n_d;
            i         <= i_d;
            timer     <= timer_d;
            leds_q    <= leds;
            botoes    <= botoes_d;
            falha     <= falha_d;
            resultado <= resultado_d;
        end
    end

    always_comb begin
        state_d     = state;
        n_d         = n;
        i_d         = i;
        timer_d     = timer;
        falha_d     = falha;
        resultado_d = resultado;
        we          = 1'b0;

        case (state)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    falha_d     = 1'b0;
                    resultado_d = 1'b0;
                    n_d         = '0;
                    timer_d     = '0;
                    state_d     = PULSO_JOGAR;
                end
            end
            PULSO_JOGAR: begin
                if (timer == TW'(T_JOGAR - 1)) begin
                    timer_d = '0;
                    n_d     = '0;
                    state_d = OBSERVA;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            OBSERVA: begin
                if (leds != '0) begin
                    timer_d = '0;
                    if (!one_hot(leds)) begin
                        falha_d = 1'b1;
                        state_d = FIM;
                    end else if (leds_q == '0) begin
                        if (n == NW'(PROF)) begin
                            falha_d = 1'b1;
                            state_d = FIM;
                        end else begin
                            we  = 1'b1;
                            n_d = n + NW'(1);
                        end
                    end
                end else if (n != '0) begin
                    // silence only counts once something has been captured
                    if (timer == TW'(T_SILENCIO - 1)) begin
                        timer_d = '0;
                        i_d     = '0;
                        state_d = REPRODUZ_PRESS;
                    end else begin
                        timer_d = timer + TW'(1);
                    end
                end
            end
            REPRODUZ_PRESS: begin
                if (timer == TW'(T_PRESS - 1)) begin
                    timer_d = '0;
                    state_d = REPRODUZ_SOLTA;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            REPRODUZ_SOLTA: begin
                if (timer == TW'(T_GAP - 1)) begin
                    timer_d = '0;
                    if (NW'(i) == n - NW'(1)) begin
                        state_d = AGUARDA_RODADA;
                    end else begin
                        i_d     = i + AW'(1);
                        state_d = REPRODUZ_PRESS;
                    end
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            AGUARDA_RODADA: begin
                n_d     = '0;
                timer_d = '0;
                state_d = OBSERVA;
            end
            default: state_d = OCIOSO;
        endcase

        if ((state != OCIOSO) && (state != FIM) && (ganhou || perdeu)) begin
            we          = 1'b0;
            timer_d     = '0;
            resultado_d = ganhou;
            state_d     = FIM;
        end
    end

    // button value is looked up with the next index so botoes is registered
    // and already valid on the first cycle of each press
    always_comb begin
        botoes_d = '0;
        if (state_d == REPRODUZ_PRESS) begin
            if (erro_en && (int'(i_d) == int'(erro_idx)))
                botoes_d = {rd_data[2:0], rd_data[3]};
            else
                botoes_d = rd_data;
        end
    end

    assign jogar     = (state == PULSO_JOGAR);
    assign ocupado   = (state != OCIOSO) && (state != FIM);
    assign fim_jogo  = (state == FIM);
    assign db_estado = state;

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: single-LED replay table plus
// multi-round, error-injection, fault and reset sequences.
module tb_jogador_automatico;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar = 1'b0;
    logic       erro_en = 1'b0;
    logic [3:0] erro_idx = 4'd0;
    logic [3:0] leds = 4'd0;
    logic       ganhou = 1'b0;
    logic       perdeu = 1'b0;
    logic       jogar;
    logic [3:0] botoes;
    logic       ocupado;
    logic       fim_jogo;
    logic       resultado;
    logic       falha;
    logic [3:0] db_estado;

    localparam int S_OCIOSO = 0;
    localparam int S_OBS    = 2;
    localparam int S_PRESS  = 3;
    localparam int S_SOLTA  = 4;
    localparam int S_AGUAR  = 5;
    localparam int S_FIM    = 6;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] led;
        logic       e_en;
        logic [3:0] e_idx;
        logic [3:0] want;
    } vec_t;

    vec_t vt [7];

    jogador_automatico #(
        .PROF       (16),
        .T_PRESS    (100),
        .T_GAP      (100),
        .T_SILENCIO (50),
        .T_JOGAR    (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .erro_en   (erro_en),
        .erro_idx  (erro_idx),
        .leds      (leds),
        .ganhou    (ganhou),
        .perdeu    (perdeu),
        .jogar     (jogar),
        .botoes    (botoes),
        .ocupado   (ocupado),
        .fim_jogo  (fim_jogo),
        .resultado (resultado),
        .falha     (falha),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("jogar_c1", jogar, 1);
        chk("falha_clr", falha, 0);
        chk("resultado_clr", resultado, 0);
        tick();
        chk("jogar_c2", jogar, 1);
        tick();
        chk("jogar_end", jogar, 0);
        chk("state_obs", db_estado, S_OBS);
    endtask

    task automatic show(input logic [3:0] v);
        leds = v;
        repeat (20) tick();
        leds = 4'd0;
        repeat (10) tick();
    endtask

    task automatic wait_press();
        int c = 0;
        while (botoes == 4'd0 && c < 400) begin
            tick();
            c++;
        end
        chk("press_seen", botoes != 4'd0, 1);
    endtask

    task automatic replay_check(input logic [3:0] seq [4], input int cnt);
        for (int k = 0; k < cnt; k++) begin
            int c;
            logic [3:0] v;
            wait_press();
            v = botoes;
            chk("press_value", v, seq[k]);
            c = 0;
            while (botoes == v && c < 400) begin
                c++;
                tick();
            end
            chk("press_len", c, 100);
            c = 0;
            while (db_estado == S_SOLTA && c < 400) begin
                chk("gap_botoes", botoes, 0);
                c++;
                tick();
            end
            chk("gap_len", c, 100);
        end
        chk("state_aguarda", db_estado, S_AGUAR);
        tick();
        chk("state_reobs", db_estado, S_OBS);
    endtask

    initial begin
        logic [3:0] seq [4];

        vt[0] = '{4'b0001, 1'b0, 4'd0, 4'b0001};
        vt[1] = '{4'b0010, 1'b0, 4'd0, 4'b0010};
        vt[2] = '{4'b0100, 1'b0, 4'd0, 4'b0100};
        vt[3] = '{4'b1000, 1'b0, 4'd0, 4'b1000};
        vt[4] = '{4'b1000, 1'b1, 4'd0, 4'b0001};
        vt[5] = '{4'b0001, 1'b1, 4'd0, 4'b0010};
        vt[6] = '{4'b0100, 1'b1, 4'd1, 4'b0100};

        reset = 1'b0;
        repeat (3) tick();
        chk("rst_state", db_estado, S_OCIOSO);
        chk("rst_jogar", jogar, 0);
        chk("rst_botoes", botoes, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_fim", fim_jogo, 0);
        chk("rst_resultado", resultado, 0);
        chk("rst_falha", falha, 0);
        reset = 1'b1;
        tick();

        // single LED held long, exact silence and press/gap timing
        start_game();
        leds = 4'b0001;
        repeat (500) tick();
        chk("no_press_during_display", db_estado, S_OBS);
        leds = 4'd0;
        repeat (49) tick();
        chk("silence_49_state", db_estado, S_OBS);
        chk("silence_49_botoes", botoes, 0);
        tick();
        chk("silence_50_state", db_estado, S_PRESS);
        seq[0] = 4'b0001; seq[1] = 4'd0; seq[2] = 4'd0; seq[3] = 4'd0;
        replay_check(seq, 1);
        ganhou = 1'b1;
        tick();
        ganhou = 1'b0;
        chk("win1_fim", fim_jogo, 1);
        chk("win1_resultado", resultado, 1);

        // three growing rounds, win at the end
        start_game();
        seq[0] = 4'b0001; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'd0;
        for (int r = 1; r <= 3; r++) begin
            for (int k = 0; k < r; k++) show(seq[k]);
            replay_check(seq, r);
        end
        ganhou = 1'b1;
        tick();
        ganhou = 1'b0;
        chk("win3_fim", fim_jogo, 1);
        chk("win3_resultado", resultado, 1);
        chk("win3_botoes", botoes, 0);
        chk("win3_ocupado", ocupado, 0);
        repeat (5) tick();
        chk("fim_hold", fim_jogo, 1);

        // deliberate wrong press at index 1
        erro_en = 1'b1;
        erro_idx = 4'd1;
        start_game();
        show(4'b0010);
        show(4'b0100);
        seq[0] = 4'b0010; seq[1] = 4'b1000; seq[2] = 4'd0; seq[3] = 4'd0;
        replay_check(seq, 2);
        perdeu = 1'b1;
        tick();
        perdeu = 1'b0;
        chk("lose_fim", db_estado, S_FIM);
        chk("lose_resultado", resultado, 0);
        erro_en = 1'b0;
        erro_idx = 4'd0;

        // table: one LED per game, loss forced mid-press
        for (int t = 0; t < 7; t++) begin
            erro_en = vt[t].e_en;
            erro_idx = vt[t].e_idx;
            start_game();
            show(vt[t].led);
            wait_press();
            chk("tbl_press", botoes, vt[t].want);
            perdeu = 1'b1;
            tick();
            perdeu = 1'b0;
            chk("tbl_fim", db_estado, S_FIM);
            chk("tbl_botoes_off", botoes, 0);
            chk("tbl_resultado", resultado, 0);
        end
        erro_en = 1'b0;
        erro_idx = 4'd0;

        // non-one-hot LED fault
        start_game();
        leds = 4'b0110;
        tick();
        leds = 4'd0;
        chk("bad_led_falha", falha, 1);
        chk("bad_led_fim", db_estado, S_FIM);

        // capture overflow
        start_game();
        for (int k = 0; k < 16; k++) begin
            leds = 4'b0001 << (k % 4);
            repeat (2) tick();
            leds = 4'd0;
            repeat (2) tick();
        end
        chk("cap16_state", db_estado, S_OBS);
        chk("cap16_falha", falha, 0);
        leds = 4'b0001;
        tick();
        leds = 4'd0;
        chk("cap17_falha", falha, 1);
        chk("cap17_fim", db_estado, S_FIM);
        chk("cap17_resultado", resultado, 0);

        // asynchronous reset during a press
        start_game();
        show(4'b0100);
        wait_press();
        chk("pre_rst_press", botoes, 4'b0100);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_botoes", botoes, 0);
        chk("async_rst_state", db_estado, S_OCIOSO);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_state", db_estado, S_OCIOSO);
        chk("post_rst_falha", falha, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
